shift_seq: RTL and testbench
============================

SHIFT_SEQ -- requirements
Module: shift_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, register width in bits (>=2).
REQ-002 SHALL have parameter CNT_W, default 3, width of the shift-amount field.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-006 SHALL have port op  input  3  operation code, table in REQ-013.
REQ-007 SHALL have port amt  input  CNT_W  number of single-bit shift steps.
REQ-008 SHALL have port data_in  input  WIDTH  parallel load value.
REQ-009 SHALL have port ser_in  input  1  serial fill bit for op 101, sampled at every step.
REQ-010 SHALL have port out  output  WIDTH  register contents, driven directly from the register.
REQ-011 SHALL have port ser_out  output  1  bit ejected by the most recent step.
REQ-012 SHALL have ports busy  output  1  (high in RUN) and done  output  1  (one-cycle completion pulse).

Function
REQ-013 SHALL implement the following single-step ops, where M = register:
- 010 logical right: {0, M[W-1:1]}
- 011 logical left: {M[W-2:0], 0}
- 100 arithmetic right: {M[W-1], M[W-1:1]}
- 101 serial right: {ser_in, M[W-1:1]}
- 110 rotate right
- 111 rotate left
REQ-014 SHALL use a 3-state FSM with states IDLE, RUN and DONE.
REQ-015 IDLE transitions SHALL be:
- start with op 000: go to DONE, no change.
- start with op 001: load out<=data_in on the same edge, go to DONE.
- start with a shift op and amt==0: go to DONE, out unchanged.
- start with a shift op and amt>0: latch op and amt into internal registers, go to RUN.
REQ-016 In RUN, the block SHALL perform exactly one step per rising edge using the latched op; the down-counter decrements at each step.
REQ-017 After the step that brings the counter to zero, the FSM SHALL enter DONE.
REQ-018 Latency SHALL be as follows: start sampled at edge T; steps occur at edges T+1..T+amt; done is high for the one cycle after edge T+amt.
REQ-019 busy SHALL be high exactly while in RUN, for amt cycles; done and busy SHALL never be high together.
REQ-020 DONE SHALL last one cycle and then return to IDLE; start SHALL be ignored in RUN and in DONE.
REQ-021 op, amt, data_in and ser_in changes during RUN SHALL NOT alter the operation in progress, except that ser_in is sampled live at each op-101 step.
REQ-022 ser_out SHALL equal the bit ejected by the latest step:
- right shifts and right rotate: M[0]
- left shift and left rotate: M[W-1]
REQ-023 ser_out SHALL hold its value through load, op 000 and amt==0 operations.
REQ-024 A maximum amt of 2^CNT_W-1 SHALL be supported; amt >= WIDTH on logical shifts SHALL yield all zeros, and on rotates SHALL wrap modulo WIDTH naturally.

Reset
REQ-025 While rst_n is low, the block SHALL asynchronously force out=0, ser_out=0, busy=0, done=0, FSM=IDLE and counter=0.
REQ-026 Reset asserted mid-RUN SHALL abandon the operation with no done pulse.
REQ-027 After rst_n rises, the first start SHALL be accepted at the next rising edge.

Verification (WIDTH=8, CNT_W=3)
REQ-028 Load: start op=001 data_in=0xA5 -> out=0xA5 after the edge; done=1 for the next cycle; busy stays 0.
REQ-029 Logical right: out=0xA5, start op=010 amt=3 -> busy=1 for 3 cycles; out=0x14; ser_out=1; then done pulse.
REQ-030 Arithmetic right: out=0x81, start op=100 amt=2 -> out=0xE0, ser_out=0.
REQ-031 Rotate left: out=0x01, start op=111 amt=7 -> out=0x80, ser_out=0; a start pulse with op=001 during busy is ignored.
REQ-032 Serial fill: out=0x00, op=101 amt=4, ser_in=1 -> out=0xF0; separately, amt=0 shift -> done next cycle, out unchanged.
REQ-033 Reset mid-RUN: rst_n=0 during cycle 2 of an amt=5 shift -> out=0x00 and busy=0 immediately; no done pulse.

Source files
------------

// File: rtl/shift_seq_if.sv
// Handshake and data bundle for shift_seq: a one-cycle start request in, register state and status out.
// The master drives the request and operands; the slave returns contents, ejected bit, busy and done.
interface shift_seq_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
);
  logic             start;
  logic [2:0]       op;
  logic [CNT_W-1:0] amt;
  logic [WIDTH-1:0] data_in;
  logic             ser_in;
  logic [WIDTH-1:0] out;
  logic             ser_out;
  logic             busy;
  logic             done;

  modport master (
    output start, op, amt, data_in, ser_in,
    input  out, ser_out, busy, done
  );

  modport slave (
    input  start, op, amt, data_in, ser_in,
    output out, ser_out, busy, done
  );
endinterface

// File: rtl/shift_seq.sv
// Multi-step shift/rotate sequencer: one single-bit step per clock for amt clocks, then a one-cycle done pulse.
// No backpressure: start is sampled only in IDLE and is dropped while busy or done.
module shift_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  shift_seq_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             ser_q, ser_d;
  logic [2:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] step_m;
  logic             step_b;

  // One step of the latched operation; ser_in is taken live for the serial fill.
  always_comb begin
    step_m = out_q;
    step_b = ser_q;
    case (op_q)
      3'b010: begin step_m = {1'b0, out_q[WIDTH-1:1]};         step_b = out_q[0];       end
      3'b011: begin step_m = {out_q[WIDTH-2:0], 1'b0};         step_b = out_q[WIDTH-1]; end
      3'b100: begin step_m = {out_q[WIDTH-1], out_q[WIDTH-1:1]}; step_b = out_q[0];     end
      3'b101: begin step_m = {bus.ser_in, out_q[WIDTH-1:1]};   step_b = out_q[0];       end
      3'b110: begin step_m = {out_q[0], out_q[WIDTH-1:1]};     step_b = out_q[0];       end
      3'b111: begin step_m = {out_q[WIDTH-2:0], out_q[WIDTH-1]}; step_b = out_q[WIDTH-1]; end
      default: begin step_m = out_q; step_b = ser_q; end
    endcase
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    ser_d   = ser_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = DONE;
          if (bus.op == 3'b001) begin
            out_d = bus.data_in;
          end else if (bus.op[2:1] != 2'b00 && bus.amt != '0) begin
            op_d    = bus.op;
            cnt_d   = bus.amt;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        out_d = step_m;
        ser_d = step_b;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      out_q   <= '0;
      ser_q   <= 1'b0;
      op_q    <= 3'b000;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      ser_q   <= ser_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.out     = out_q;
  assign bus.ser_out = ser_q;
  assign bus.busy    = (state_q == RUN);
  assign bus.done    = (state_q == DONE);

endmodule

// File: tb/tb_shift_seq.sv
// Bench for shift_seq: directed literal cases plus randomized traffic against a step-count model.
module tb_shift_seq;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  shift_seq_if #(.WIDTH(8), .CNT_W(3)) bus ();

  shift_seq #(.WIDTH(8), .CNT_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Single-step reference written as plain arithmetic on an 8-bit value.
  function automatic logic [7:0] mstep(input logic [2:0] o, input logic [7:0] m,
                                       input logic s, output logic ej);
    int v;
    v  = int'(m);
    ej = 1'b0;
    case (o)
      3'd2: begin ej = m[0]; v = v / 2; end
      3'd3: begin ej = m[7]; v = (v * 2) % 256; end
      3'd4: begin ej = m[0]; v = v / 2 + (v >= 128 ? 128 : 0); end
      3'd5: begin ej = m[0]; v = v / 2 + (s ? 128 : 0); end
      3'd6: begin ej = m[0]; v = v / 2 + (v % 2) * 128; end
      default: begin ej = m[7]; v = (v * 2) % 256 + v / 128; end
    endcase
    return v[7:0];
  endfunction

  // Model: value, last ejected bit, remaining step count, pending done pulse.
  logic [7:0] m_val;
  logic       m_ser;
  int         m_rem;
  bit         m_done;
  logic [2:0] m_op;

  initial begin
    logic       s_start, s_ser, ej;
    logic [2:0] s_op, s_amt;
    logic [7:0] s_data;
    m_val = 8'h00; m_ser = 1'b0; m_rem = 0; m_done = 0; m_op = 3'd0;
    forever begin
      @(posedge clk);
      s_start = bus.start; s_op = bus.op; s_amt = bus.amt;
      s_data = bus.data_in; s_ser = bus.ser_in;
      #1;
      if (!rst_n) begin
        m_val = 8'h00; m_ser = 1'b0; m_rem = 0; m_done = 0;
      end else if (m_done) begin
        m_done = 0;
      end else if (m_rem > 0) begin
        m_val = mstep(m_op, m_val, s_ser, ej);
        m_ser = ej;
        m_rem--;
        if (m_rem == 0) m_done = 1;
      end else if (s_start) begin
        if (s_op == 3'd1) begin
          m_val = s_data; m_done = 1;
        end else if (s_op == 3'd0 || s_amt == 3'd0) begin
          m_done = 1;
        end else begin
          m_op = s_op; m_rem = int'(s_amt);
        end
      end
      chk("cyc_out",  {24'h0, bus.out}, {24'h0, m_val});
      chk("cyc_ser",  {31'h0, bus.ser_out}, {31'h0, m_ser});
      chk("cyc_busy", {31'h0, bus.busy}, {31'h0, (m_rem > 0)});
      chk("cyc_done", {31'h0, bus.done}, {31'h0, m_done});
    end
  end

  task automatic run_op(input logic [2:0] o, input logic [2:0] a, input logic [7:0] d,
                        input logic s, input bit inject, output int nbusy, output bit got_done);
    bus.start = 1'b1; bus.op = o; bus.amt = a; bus.data_in = d; bus.ser_in = s;
    @(negedge clk);
    bus.start = 1'b0;
    nbusy = 0;
    got_done = 0;
    for (int i = 0; i < 40 && !got_done; i++) begin
      if (bus.done) begin
        got_done = 1;
      end else begin
        if (bus.busy) nbusy++;
        if (inject && nbusy == 3) begin
          bus.start = 1'b1; bus.op = 3'b001; bus.data_in = 8'hFF;
        end else begin
          bus.start = 1'b0;
        end
        @(negedge clk);
      end
    end
    bus.start = 1'b0;
    if (!got_done) chk("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int         nb;
    bit         gd;
    logic       ej;
    logic [7:0] mv;
    total = 0; bad = 0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.op = 3'd0; bus.amt = 3'd0; bus.data_in = 8'h00; bus.ser_in = 1'b0;

    // Pin the reference step function with hand values.
    mv = mstep(3'd4, 8'h81, 1'b0, ej);
    chk("model_asr", {23'h0, ej, mv}, {23'h0, 1'b1, 8'hC0});
    mv = mstep(3'd7, 8'h80, 1'b0, ej);
    chk("model_rol", {23'h0, ej, mv}, {23'h0, 1'b1, 8'h01});
    mv = mstep(3'd5, 8'h02, 1'b1, ej);
    chk("model_ser", {23'h0, ej, mv}, {23'h0, 1'b0, 8'h81});

    repeat (2) @(negedge clk);
    chk("rst_state", {20'h0, bus.out, bus.ser_out, bus.busy, bus.done},
        {20'h0, 8'h00, 1'b0, 1'b0, 1'b0});
    rst_n = 1'b1;

    run_op(3'b001, 3'd0, 8'hA5, 1'b0, 0, nb, gd);
    chk("load_out", {24'h0, bus.out}, 32'hA5);
    chk("load_done_nobusy", {31'h0, gd} + 32'(nb) * 2, 32'd1);
    @(negedge clk);

    run_op(3'b010, 3'd3, 8'h00, 1'b0, 0, nb, gd);
    chk("lsr_busy", 32'(nb), 32'd3);
    chk("lsr_out", {24'h0, bus.out}, 32'h14);
    chk("lsr_ser", {31'h0, bus.ser_out}, 32'd1);
    @(negedge clk);

    run_op(3'b001, 3'd0, 8'h81, 1'b0, 0, nb, gd);
    @(negedge clk);
    run_op(3'b100, 3'd2, 8'h00, 1'b0, 0, nb, gd);
    chk("asr_out", {23'h0, bus.ser_out, bus.out}, 32'h0E0);
    @(negedge clk);

    run_op(3'b001, 3'd0, 8'h01, 1'b0, 0, nb, gd);
    @(negedge clk);
    run_op(3'b111, 3'd7, 8'h00, 1'b0, 1, nb, gd);
    chk("rol_busy", 32'(nb), 32'd7);
    chk("rol_out", {23'h0, bus.ser_out, bus.out}, 32'h080);
    @(negedge clk);

    run_op(3'b001, 3'd0, 8'h00, 1'b0, 0, nb, gd);
    @(negedge clk);
    run_op(3'b101, 3'd4, 8'h00, 1'b1, 0, nb, gd);
    chk("ser_out_val", {24'h0, bus.out}, 32'hF0);
    @(negedge clk);
    run_op(3'b110, 3'd0, 8'h00, 1'b0, 0, nb, gd);
    chk("amt0", {22'h0, gd, bus.done, bus.out}, {22'h0, 1'b1, 1'b1, 8'hF0});
    @(negedge clk);

    // Abandon an amt=5 shift in its second busy cycle.
    run_op(3'b001, 3'd0, 8'hFF, 1'b0, 0, nb, gd);
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'b010; bus.amt = 3'd5;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    chk("pre_rst_busy", {31'h0, bus.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst", {22'h0, bus.out, bus.busy, bus.done}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_no_done", {31'h0, bus.done}, 32'd0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_no_done", {31'h0, bus.done}, 32'd0);
    end

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst_n        = ($urandom_range(0, 299) != 0);
      bus.start    = ($urandom_range(0, 2) == 0);
      bus.op       = 3'($urandom);
      bus.amt      = 3'($urandom);
      bus.data_in  = 8'($urandom);
      bus.ser_in   = 1'($urandom);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.start = 1'b0;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
